uart_cmd_parser: RTL

- Host-command front end for the GPU: consumes the byte stream from `uart_core` (`rx_data`/`rx_valid`) and drives its transmit side (`tx_data`/`tx_valid`/`tx_ready`).
- Decodes fixed 8-byte frames into single 32-bit register-bus reads/writes, waits for bus completion, and returns an ACK/NAK/read-data response.
- It is the only bus master reachable from the host link.

---
 rtl/uart_cmd_pkg.sv | 43 ++++
 rtl/uart_cmd_parser_resp_ser.sv | 63 ++++++
 rtl/uart_cmd_parser.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and response helpers for the host command parser.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] ACK_BYTE    = 8'h5A;
  localparam logic [7:0] NAK_BYTE    = 8'hEE;
  localparam logic [7:0] OP_WRITE    = 8'h01;
  localparam logic [7:0] OP_READ     = 8'h02;
  localparam logic [7:0] NAK_CSUM    = 8'h01;
  localparam logic [7:0] NAK_OP      = 8'h02;
  localparam logic [7:0] NAK_TIMEOUT = 8'h03;

  localparam int         FRAME_LEN   = 8;
  // Byte index (counted after the sync byte) that carries the checksum.
  localparam logic [2:0] CSUM_IDX    = 3'(FRAME_LEN - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_EXEC,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [2:0]  count;
    logic [39:0] payload;
  } resp_t;

  function automatic resp_t nak_resp(input logic [7:0] code);
    resp_t r;
    r.count   = 3'd2;
    r.payload = {24'h0, code, NAK_BYTE};
    return r;
  endfunction

  function automatic resp_t ack_resp(input logic is_read, input logic [31:0] rdata);
    resp_t r;
    r.count   = is_read ? 3'd5 : 3'd1;
    r.payload = {(is_read ? rdata : 32'h0), ACK_BYTE};
    return r;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_resp_ser.sv
// Response serializer: sends 1..5 payload bytes, LSB first, over a valid/ready handshake.
module uart_resp_ser
  import uart_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [2:0]  count,
  input  logic [39:0] payload,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        done
);

  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [31:0] rest_q, rest_d;
  logic [2:0]  left_q, left_d;
  logic        xfer;

  assign xfer     = tx_valid_q && tx_ready;
  assign done     = xfer && (left_q == 3'd0);
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rest_d     = rest_q;
    left_d     = left_q;
    if (load) begin
      tx_valid_d = 1'b1;
      tx_data_d  = payload[7:0];
      rest_d     = payload[39:8];
      left_d     = count - 3'd1;
    end else if (xfer) begin
      if (left_q == 3'd0) begin
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end else begin
        tx_data_d = rest_q[7:0];
        rest_d    = {8'h00, rest_q[31:8]};
        left_d    = left_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      rest_q     <= 32'h0;
      left_q     <= 3'd0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rest_q     <= rest_d;
      left_q     <= left_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Host command front end: decodes 8-byte UART frames into single register-bus
// reads/writes and returns ACK, NAK or read data.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned FCLK_HZ     = 100_000_000,
  parameter int unsigned GAP_TIMEOUT = FCLK_HZ / 100,
  parameter int unsigned BUS_TIMEOUT = 1024
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam int BUS_W = $clog2(BUS_TIMEOUT + 1);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  xor_q, xor_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [BUS_W-1:0] bus_cnt_q, bus_cnt_d;
  logic        bus_we_q, bus_we_d;
  logic        bus_re_q, bus_re_d;
  logic [7:0]  bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;

  logic  frame_end, csum_ok, op_ok, gap_expire, bus_expire;
  logic  ser_load, ser_done;
  resp_t resp;

  assign frame_end  = (state_q == ST_RECV) && rx_valid && (idx_q == CSUM_IDX);
  assign csum_ok    = (rx_data == xor_q);
  assign op_ok      = (op_q == OP_WRITE) || (op_q == OP_READ);
  assign gap_expire = (state_q == ST_RECV) && !rx_valid &&
                      (gap_q == GAP_W'(GAP_TIMEOUT - 1));
  // The ack is still honoured in the last allowed cycle.
  assign bus_expire = (state_q == ST_EXEC) && !bus_ack &&
                      (bus_cnt_q == BUS_W'(BUS_TIMEOUT - 1));

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_RECV;
      ST_RECV: begin
        if (frame_end)       state_d = (csum_ok && op_ok) ? ST_EXEC : ST_RESP;
        else if (gap_expire) state_d = ST_IDLE;
      end
      ST_EXEC: if (bus_ack || bus_expire) state_d = ST_RESP;
      ST_RESP: if (ser_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    xor_d       = xor_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    bus_we_d    = bus_we_q;
    bus_re_d    = bus_re_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    ser_load    = 1'b0;
    resp        = '0;

    gap_d     = (state_q == ST_RECV && !rx_valid && !gap_expire) ? gap_q + GAP_W'(1) : '0;
    bus_cnt_d = (state_q == ST_EXEC && !bus_ack && !bus_expire) ? bus_cnt_q + BUS_W'(1) : '0;

    if (state_q == ST_IDLE) begin
      idx_d = 3'd0;
      xor_d = 8'h00;
    end

    if (state_q == ST_RECV && rx_valid) begin
      idx_d = idx_q + 3'd1;
      if (idx_q != CSUM_IDX) xor_d = xor_q ^ rx_data;
      case (idx_q)
        3'd0:    op_d          = rx_data;
        3'd1:    addr_d        = rx_data;
        3'd2:    data_d[7:0]   = rx_data;
        3'd3:    data_d[15:8]  = rx_data;
        3'd4:    data_d[23:16] = rx_data;
        3'd5:    data_d[31:24] = rx_data;
        default: ;
      endcase
    end

    if (frame_end) begin
      if (!csum_ok) begin
        ser_load = 1'b1;
        resp     = nak_resp(NAK_CSUM);
      end else if (!op_ok) begin
        ser_load = 1'b1;
        resp     = nak_resp(NAK_OP);
      end else begin
        bus_we_d    = (op_q == OP_WRITE);
        bus_re_d    = (op_q == OP_READ);
        bus_addr_d  = addr_q;
        bus_wdata_d = data_q;
      end
    end

    if (state_q == ST_EXEC && (bus_ack || bus_expire)) begin
      bus_we_d = 1'b0;
      bus_re_d = 1'b0;
      ser_load = 1'b1;
      resp     = bus_ack ? ack_resp(bus_re_q, bus_rdata) : nak_resp(NAK_TIMEOUT);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= 3'd0;
      xor_q       <= 8'h00;
      gap_q       <= '0;
      bus_cnt_q   <= '0;
      bus_we_q    <= 1'b0;
      bus_re_q    <= 1'b0;
      bus_addr_q  <= 8'h00;
      bus_wdata_q <= 32'h0;
    end else begin
      idx_q       <= idx_d;
      xor_q       <= xor_d;
      gap_q       <= gap_d;
      bus_cnt_q   <= bus_cnt_d;
      bus_we_q    <= bus_we_d;
      bus_re_q    <= bus_re_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Frame buffer is pure data; it is always rewritten before it is used.
  always_ff @(posedge CLK) begin
    op_q   <= op_d;
    addr_q <= addr_d;
    data_q <= data_d;
  end

  uart_resp_ser u_ser (
    .clk      (CLK),
    .rst_n    (rst_n),
    .load     (ser_load),
    .count    (resp.count),
    .payload  (resp.payload),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .done     (ser_done)
  );

  assign bus_we    = bus_we_q;
  assign bus_re    = bus_re_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule
